// File: rtl/env_mix_pkg.sv
// Shared constants for the envelope mixer.
//   DEF_PWM_DEPTH : default width of the base duty cycle (overridable by `PWM_DEPTH)
//   DEF_DATAWIDTH : default width of the mixed duty cycle (overridable by `DATAWIDTH)
//   DEF_ENV_W     : default envelope level width
//   DEF_MUL_W     : default envelope depth multiplier width
//   DC_MAX        : saturation ceiling for the default DATAWIDTH
//   max3()        : width helper used to size intermediate sums
`ifndef PWM_DEPTH
`define PWM_DEPTH 8
`endif
`ifndef DATAWIDTH
`define DATAWIDTH 12
`endif

package env_mix_pkg;

    localparam int unsigned DEF_PWM_DEPTH = `PWM_DEPTH;
    localparam int unsigned DEF_DATAWIDTH = `DATAWIDTH;
    localparam int unsigned DEF_ENV_W     = 7;
    localparam int unsigned DEF_MUL_W     = 5;
    localparam int unsigned DC_MAX        = (1 << DEF_DATAWIDTH) - 1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/env_mix_sat_add.sv
// Unsigned saturating adder, purely combinational.
//   i_a : first addend  (A_W bits)
//   i_b : second addend (B_W bits)
//   o_y : i_a + i_b clamped to 2**OUT_W-1 (OUT_W bits)
module sat_add
    import env_mix_pkg::*;
#(
    parameter int unsigned A_W   = DEF_ENV_W + DEF_MUL_W,
    parameter int unsigned B_W   = DEF_PWM_DEPTH,
    parameter int unsigned OUT_W = DEF_DATAWIDTH
) (
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    output logic [OUT_W-1:0] o_y
);

    // One bit wider than the widest operand or result, so the sum can never wrap
    // and anything above the ceiling is visible to the compare.
    localparam int unsigned SUM_W = max3(A_W, B_W, OUT_W) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_sum = SUM_W'(i_a) + SUM_W'(i_b);
        if (w_sum > SAT_MAX) begin
            o_y = '1;
        end else begin
            o_y = w_sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/env_mix.sv
// Envelope mixer: DC_POST = sat(DC_PRE + ENV*MUL), three-stage pipeline,
// one result per clock, no handshake.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears all pipeline state
//   ENV     : envelope level (ENV_W bits, unsigned)
//   DC_PRE  : base duty cycle (PWM_DEPTH bits, unsigned)
//   MUL     : envelope depth multiplier (MUL_W bits, unsigned)
//   DC_POST : mixed, saturated duty cycle (DATAWIDTH bits, registered)
module env_mix
    import env_mix_pkg::*;
#(
    parameter int unsigned PWM_DEPTH = DEF_PWM_DEPTH,
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned ENV_W     = DEF_ENV_W,
    parameter int unsigned MUL_W     = DEF_MUL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ENV_W-1:0]     ENV,
    input  logic [PWM_DEPTH-1:0] DC_PRE,
    input  logic [MUL_W-1:0]     MUL,
    output logic [DATAWIDTH-1:0] DC_POST
);

    localparam int unsigned PROD_W = ENV_W + MUL_W;

    // Stage 1: input capture
    logic [ENV_W-1:0]     r_env;
    logic [MUL_W-1:0]     r_mul;
    logic [PWM_DEPTH-1:0] r_dc_pre_s1;
    // Stage 2: product, base duty cycle carried alongside
    logic [PROD_W-1:0]    r_prod;
    logic [PWM_DEPTH-1:0] r_dc_pre_s2;
    // Stage 3: saturated result
    logic [DATAWIDTH-1:0] r_dc_post;
    logic [DATAWIDTH-1:0] w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_env       <= '0;
            r_mul       <= '0;
            r_dc_pre_s1 <= '0;
        end else begin
            r_env       <= ENV;
            r_mul       <= MUL;
            r_dc_pre_s1 <= DC_PRE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod      <= '0;
            r_dc_pre_s2 <= '0;
        end else begin
            // Operands widened first so the full product is kept.
            r_prod      <= PROD_W'(r_env) * PROD_W'(r_mul);
            r_dc_pre_s2 <= r_dc_pre_s1;
        end
    end

    sat_add #(
        .A_W   (PROD_W),
        .B_W   (PWM_DEPTH),
        .OUT_W (DATAWIDTH)
    ) u_sat_add (
        .i_a (r_prod),
        .i_b (r_dc_pre_s2),
        .o_y (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dc_post <= '0;
        end else begin
            r_dc_post <= w_sat;
        end
    end

    assign DC_POST = r_dc_post;

endmodule

// File: tb/tb_env_mix.sv
module tb_env_mix;

    logic        clk;
    logic        rst_n;
    logic [6:0]  ENV;
    logic [7:0]  DC_PRE;
    logic [4:0]  MUL;
    logic [11:0] DC_POST;

    typedef struct {
        int unsigned exp;
        int unsigned due;
        string       tag;
    } sb_item_t;

    sb_item_t    sb[$];
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_err;

    env_mix #(
        .PWM_DEPTH (8),
        .DATAWIDTH (12),
        .ENV_W     (7),
        .MUL_W     (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ENV     (ENV),
        .DC_PRE  (DC_PRE),
        .MUL     (MUL),
        .DC_POST (DC_POST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned model(input int unsigned env,
                                          input int unsigned pre,
                                          input int unsigned mul);
        int unsigned s;
        s = env * mul + pre;
        return (s > 4095) ? 4095 : s;
    endfunction

    task automatic compare(input string tag, input int unsigned exp);
        n_cmp++;
        assert (DC_POST === 12'(exp)) else begin
            n_err++;
            $display("FAIL %s: DC_POST=%0d expected=%0d (cycle %0d)", tag, DC_POST, exp, cyc);
            $error("check %s observed %0d expected %0d", tag, DC_POST, exp);
        end
    endtask

    // Advance one rising edge, then check every scoreboard entry due now.
    task automatic tick();
        sb_item_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            compare(e.tag, e.exp);
        end
    endtask

    task automatic push(input int unsigned exp, input int unsigned due, input string tag);
        sb_item_t e;
        e.exp = exp;
        e.due = due;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int unsigned env, input int unsigned pre,
                        input int unsigned mul, input string tag);
        ENV    = 7'(env);
        DC_PRE = 8'(pre);
        MUL    = 5'(mul);
        push(model(env, pre, mul), cyc + 3, tag);
        tick();
    endtask

    // After release the pipeline holds zeros for two edges.
    task automatic release_reset();
        rst_n = 1'b1;
        push(0, cyc + 1, "rst_flush1");
        push(0, cyc + 2, "rst_flush2");
    endtask

    initial begin
        cyc    = 0;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        ENV    = '0;
        DC_PRE = '0;
        MUL    = '0;
        #1;
        compare("reset_state", 0);
        ENV    = 7'd50;
        DC_PRE = 8'd200;
        MUL    = 5'd20;
        tick();
        compare("reset_hold", 0);
        tick();
        compare("reset_hold2", 0);
        release_reset();

        // Basic mix
        repeat (4) step(2, 5, 4, "basic");
        // Raw 4130 clamps
        repeat (4) step(125, 255, 31, "sat_4130");
        // Largest possible inputs
        repeat (2) step(127, 255, 31, "sat_max");
        // Exact ceiling passes, one above clamps
        repeat (2) step(124, 251, 31, "ceil_4095");
        repeat (2) step(124, 252, 31, "ceil_4096");
        // All-zero inputs
        repeat (2) step(0, 0, 0, "all_zero");
        // Latency: the step must not show up before the third edge
        repeat (3) step(0, 0, 1, "lat_before");
        repeat (4) step(10, 0, 1, "lat_after");
        // Streaming, one set per cycle
        for (int k = 0; k < 10; k++) step(k, 0, 1, "stream");
        // Mixed streaming with varied operands
        for (int k = 20; k < 26; k++) step(k, k * 7, k % 32, "stream_mix");

        // Asynchronous reset mid-stream, between edges
        #2;
        rst_n = 1'b0;
        #1;
        compare("rst_async", 0);
        sb.delete();
        tick();
        compare("rst_during", 0);
        tick();
        compare("rst_during2", 0);
        release_reset();
        repeat (4) step(7, 9, 6, "post_rst");
        for (int k = 0; k < 4; k++) step(100 + k, 200, 30 + (k % 2), "post_rst_stream");

        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
            $error("scoreboard not drained");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
